tw_master: RTL and testbench
============================

TW_MASTER -- requirements
Module: tw_master

Interface
REQ-001 SHALL have parameter TWM_ADDRESS_BITS, default 10, address field width on the three-wire bus.
REQ-002 SHALL have parameter TWM_DATA_BITS, default 32, data word width on the bus.
REQ-003 SHALL have parameter TWM_CLK_DIV, default 4, in_clk cycles per tw_bus_clock half-period; legal values >= 2.
REQ-004 SHALL have ports, one clock with synchronous active-high reset:
  in_clk  input  1  system clock, all logic on rising edge
  in_rst  input  1  synchronous active-high reset
  in_start  input  1  one-cycle request to begin a frame
  in_wr  input  1  1 = write frame, 0 = read frame (sampled with in_start)
  in_addr  input  TWM_ADDRESS_BITS  start word address (sampled with in_start)
  in_len  input  8  burst length minus one, 0..255 = 1..256 words (sampled with in_start)
  in_wdata  input  TWM_DATA_BITS  write word; first word sampled with in_start, later words on out_wdata_req
  out_wdata_req  output  1  one-cycle pop strobe: in_wdata captured this cycle as next word
  out_rdata  output  TWM_DATA_BITS  last completed read word
  out_rdata_valid  output  1  one-cycle strobe, out_rdata updated
  out_busy  output  1  frame in progress
  out_done  output  1  one-cycle strobe at frame end
  tw_bus_clock  output  1  serial clock, idle low
  tw_bus_chipselect  output  1  active-low frame select, idle high
  tw_bus_data  inout  1  bidirectional serial data, high-Z when not driven

Function
REQ-005 SHALL accept in_start only in IDLE; in_start while out_busy=1 SHALL be ignored with no side effect.
REQ-006 SHALL implement states IDLE -> CMD -> (WDATA | RDATA) -> HOLD -> IDLE.
REQ-007 SHALL, in the cycle after an accepted start (T0), drive chipselect low, out_busy high, bus clock low, and drive tw_bus_data = in_wr.
REQ-008 SHALL generate tw_bus_clock from a half-period counter: rising edge k (k = 0..) at T0+(2k+1)*DIV, falling edge k at T0+(2k+2)*DIV.
REQ-009 SHALL change driven data only at clock falling edges (or T0), so each bit is stable DIV cycles around every rising edge.
REQ-010 CMD SHALL shift out 1+TWM_ADDRESS_BITS bits: mode bit, then in_addr MSB first.
REQ-011 WDATA SHALL shift out (in_len+1) words, each MSB first, back to back with no gap bits.
REQ-012 SHALL pulse out_wdata_req for one cycle at the falling edge that completes each non-final write word, capturing in_wdata that same cycle; no pulse after the final word.
REQ-013 RDATA SHALL release tw_bus_data (high-Z) from the falling edge after the last address bit through frame end.
REQ-014 RDATA SHALL sample tw_bus_data at each falling edge following a data-phase rising edge, assembling words MSB first.
REQ-015 SHALL, on the cycle the last bit of each read word is sampled, update out_rdata and pulse out_rdata_valid for one cycle; (in_len+1) pulses per read frame.
REQ-016 Total rising edges per frame SHALL equal 1+TWM_ADDRESS_BITS+(in_len+1)*TWM_DATA_BITS.
REQ-017 HOLD SHALL keep clock low and chipselect low for one half-period after the last falling edge, then drive chipselect high.
REQ-018 out_done SHALL pulse and out_busy SHALL drop in the same cycle chipselect returns high; a new in_start SHALL be accepted from the following cycle.
REQ-019 Word counter SHALL be 9 bits so in_len=255 yields exactly 256 words without wrap.
REQ-020 Address auto-increment SHALL be left to the slave; tw_master SHALL send the address only once per frame.

Reset
REQ-021 in_rst=1 SHALL, on the next in_clk edge, force IDLE: chipselect 1, tw_bus_clock 0, tw_bus_data high-Z, out_busy 0, out_done 0, out_wdata_req 0, out_rdata_valid 0, out_rdata 0.
REQ-022 Reset mid-frame SHALL abort immediately with no out_done, out_rdata_valid or out_wdata_req pulse.
REQ-023 in_rst SHALL take priority over a coincident in_start.

Verification
REQ-024 Reset: hold in_rst 3 cycles, toggle in_start -> all outputs at REQ-021 values, bus stays idle.
REQ-025 Single write, DIV=4, addr 0x155, data 0xDEADBEEF, len 0 -> bits 1,0101010101,DEADBEEF MSB first on 43 rising edges; chipselect high and out_done at T0+348; zero out_wdata_req pulses.
REQ-026 Burst write len 2, words 0x11111111/0x22222222/0x33333333 -> 107 rising edges; out_wdata_req pulses twice, at word boundaries; slave model memory holds the three words at addr, addr+1, addr+2.
REQ-027 Read, addr 0x3FF, len 1, slave model preloaded 0x12345678, 0x9ABCDEF0 -> bus high-Z after 11th bit; two out_rdata_valid pulses with out_rdata 0x12345678 then 0x9ABCDEF0; out_done after.
REQ-028 in_start during a frame -> ignored, frame unchanged; in_rst asserted at the 20th rising edge -> bus idle next cycle, no out_done; next in_start runs a complete frame.

Source files
------------

// File: rtl/tw_master.sv
`default_nettype none
// ============================================================================
//  Module   : tw_master
//  Purpose  : Three-wire serial bus master. Sends a mode bit and a start
//             address, then streams a burst of write words out, or samples a
//             burst of read words in, on a divided serial clock.
//  Revision : 1.0  initial release
// ============================================================================
module tw_master #(
  parameter int TWM_ADDRESS_BITS = 10,
  parameter int TWM_DATA_BITS    = 32,
  parameter int TWM_CLK_DIV      = 4
) (
  input  logic                        in_clk,
  input  logic                        in_rst,
  input  logic                        in_start,
  input  logic                        in_wr,
  input  logic [TWM_ADDRESS_BITS-1:0] in_addr,
  input  logic [7:0]                  in_len,
  input  logic [TWM_DATA_BITS-1:0]    in_wdata,
  output logic                        out_wdata_req,
  output logic [TWM_DATA_BITS-1:0]    out_rdata,
  output logic                        out_rdata_valid,
  output logic                        out_busy,
  output logic                        out_done,
  output logic                        tw_bus_clock,
  output logic                        tw_bus_chipselect,
  inout  wire                         tw_bus_data
);

  localparam int AB   = TWM_ADDRESS_BITS;
  localparam int DB   = TWM_DATA_BITS;
  localparam int MAXB = (AB + 1 > DB) ? AB + 1 : DB;
  localparam int BCW  = $clog2(MAXB);
  localparam int DCW  = $clog2(TWM_CLK_DIV);

  localparam logic [BCW-1:0] LAST_ADDR_BIT = BCW'(AB);
  localparam logic [BCW-1:0] LAST_DATA_BIT = BCW'(DB - 1);
  localparam logic [DCW-1:0] DIV_LAST      = DCW'(TWM_CLK_DIV - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CMD   = 3'd1;
  localparam logic [2:0] ST_WDATA = 3'd2;
  localparam logic [2:0] ST_RDATA = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;

  logic [2:0]     state;
  logic [DCW-1:0] div_cnt;
  logic           sclk;
  logic           cs_n;
  logic           oe;
  logic           sdo;
  logic           wr_mode;
  logic [AB-1:0]  addr_sr;
  logic [DB-1:0]  wsr;
  logic [DB-2:0]  rsr;
  logic [BCW-1:0] bit_cnt;
  logic [8:0]     word_cnt;   // words still to transfer after the current one
  logic [DB-1:0]  rdata;
  logic           rdata_valid;
  logic           done;

  logic          tick;
  logic          fall;
  logic          rise;
  logic [DB-1:0] rsr_next;

  assign tick     = (div_cnt == DIV_LAST);
  assign fall     = tick & sclk;
  assign rise     = tick & ~sclk;
  assign rsr_next = {rsr, tw_bus_data};

  // Pop strobe is high in the cycle whose closing edge loads the next word,
  // so the word is on the line right at the falling edge that ends the last.
  assign out_wdata_req = (state == ST_WDATA) && fall &&
                         (bit_cnt == LAST_DATA_BIT) && (word_cnt != 9'd0);

  assign out_rdata         = rdata;
  assign out_rdata_valid   = rdata_valid;
  assign out_busy          = (state != ST_IDLE);
  assign out_done          = done;
  assign tw_bus_clock      = sclk;
  assign tw_bus_chipselect = cs_n;
  assign tw_bus_data       = oe ? sdo : 1'bz;

  // Frame sequencer: clock divider, bit/word counters and shift registers.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state       <= ST_IDLE;
      div_cnt     <= '0;
      sclk        <= 1'b0;
      cs_n        <= 1'b1;
      oe          <= 1'b0;
      sdo         <= 1'b0;
      wr_mode     <= 1'b0;
      addr_sr     <= '0;
      wsr         <= '0;
      rsr         <= '0;
      bit_cnt     <= '0;
      word_cnt    <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      done        <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      done        <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_start) begin
            state    <= ST_CMD;
            cs_n     <= 1'b0;
            sclk     <= 1'b0;
            div_cnt  <= '0;
            oe       <= 1'b1;
            sdo      <= in_wr;
            wr_mode  <= in_wr;
            addr_sr  <= in_addr;
            wsr      <= in_wdata;
            word_cnt <= {1'b0, in_len};
            bit_cnt  <= '0;
          end
        end
        ST_CMD, ST_WDATA, ST_RDATA: begin
          div_cnt <= tick ? '0 : div_cnt + 1'b1;
          if (rise) begin
            sclk <= 1'b1;
          end
          if (fall) begin
            sclk <= 1'b0;
            if (state == ST_CMD) begin
              if (bit_cnt == LAST_ADDR_BIT) begin
                bit_cnt <= '0;
                if (wr_mode) begin
                  state <= ST_WDATA;
                  sdo   <= wsr[DB-1];
                end else begin
                  state <= ST_RDATA;
                  oe    <= 1'b0;
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
                sdo     <= addr_sr[AB-1];
                addr_sr <= {addr_sr[AB-2:0], 1'b0};
              end
            end else if (state == ST_WDATA) begin
              if (bit_cnt == LAST_DATA_BIT) begin
                bit_cnt <= '0;
                if (word_cnt == 9'd0) begin
                  state <= ST_HOLD;
                  oe    <= 1'b0;
                end else begin
                  word_cnt <= word_cnt - 1'b1;
                  wsr      <= in_wdata;
                  sdo      <= in_wdata[DB-1];
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
                sdo     <= wsr[DB-2];
                wsr     <= {wsr[DB-2:0], 1'b0};
              end
            end else begin
              rsr <= rsr_next[DB-2:0];
              if (bit_cnt == LAST_DATA_BIT) begin
                bit_cnt     <= '0;
                rdata       <= rsr_next;
                rdata_valid <= 1'b1;
                if (word_cnt == 9'd0) begin
                  state <= ST_HOLD;
                end else begin
                  word_cnt <= word_cnt - 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
        end
        ST_HOLD: begin
          if (tick) begin
            state   <= ST_IDLE;
            cs_n    <= 1'b1;
            done    <= 1'b1;
            div_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tw_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tw_master
//  Purpose  : Directed bench for tw_master with a bus slave model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tw_master;

  localparam int AB  = 10;
  localparam int DB  = 32;
  localparam int DIV = 4;

  logic          in_clk = 1'b0;
  logic          in_rst = 1'b0;
  logic          in_start = 1'b0;
  logic          in_wr = 1'b0;
  logic [AB-1:0] in_addr = '0;
  logic [7:0]    in_len = '0;
  logic [DB-1:0] in_wdata = '0;
  logic          out_wdata_req;
  logic [DB-1:0] out_rdata;
  logic          out_rdata_valid;
  logic          out_busy;
  logic          out_done;
  logic          tw_bus_clock;
  logic          tw_bus_chipselect;
  wire           tw_bus_data;

  logic s_oe  = 1'b0;
  logic s_bit = 1'b0;
  assign tw_bus_data = s_oe ? s_bit : 1'bz;
  pulldown (tw_bus_data);

  tw_master #(
    .TWM_ADDRESS_BITS(AB),
    .TWM_DATA_BITS   (DB),
    .TWM_CLK_DIV     (DIV)
  ) dut (
    .in_clk           (in_clk),
    .in_rst           (in_rst),
    .in_start         (in_start),
    .in_wr            (in_wr),
    .in_addr          (in_addr),
    .in_len           (in_len),
    .in_wdata         (in_wdata),
    .out_wdata_req    (out_wdata_req),
    .out_rdata        (out_rdata),
    .out_rdata_valid  (out_rdata_valid),
    .out_busy         (out_busy),
    .out_done         (out_done),
    .tw_bus_clock     (tw_bus_clock),
    .tw_bus_chipselect(tw_bus_chipselect),
    .tw_bus_data      (tw_bus_data)
  );

  always #5 in_clk = ~in_clk;

  int cyc = 0;
  always @(posedge in_clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Slave model: samples on bus-clock rising edges, drives read bits right after them.
  logic [DB-1:0] mem [0:1023];
  int            s_rises = 0;
  int            frame_rises = 0;
  logic          s_prev = 1'b0;
  logic          s_mode = 1'b0;
  logic [AB-1:0] s_addr = '0;
  logic [DB-1:0] s_word = '0;

  always @(negedge in_clk) begin
    int j, wi, bi;
    logic [AB-1:0] idx;
    if (tw_bus_chipselect) begin
      if (s_rises != 0) frame_rises = s_rises;
      s_rises = 0;
      s_oe    = 1'b0;
    end else if (tw_bus_clock && !s_prev) begin
      if (s_rises == 0) begin
        s_mode = tw_bus_data;
      end else if (s_rises <= AB) begin
        s_addr = {s_addr[AB-2:0], tw_bus_data};
      end else begin
        j   = s_rises - AB - 1;
        wi  = j / DB;
        bi  = DB - 1 - (j % DB);
        idx = s_addr + AB'(wi);
        if (s_mode) begin
          s_word = {s_word[DB-2:0], tw_bus_data};
          if (bi == 0) mem[idx] = s_word;
        end else begin
          s_oe  = 1'b1;
          s_bit = mem[idx][bi];
        end
      end
      s_rises++;
    end
    s_prev = tw_bus_clock;
  end

  typedef struct {
    logic          wr;
    logic [AB-1:0] addr;
    logic [7:0]    len;
    logic [DB-1:0] w0, w1, w2;
    int            exp_rises;
    int            exp_cycles;   // T0 to chipselect high
    int            exp_req;
    int            exp_valid;
  } vec_t;

  task automatic run_frame(input vec_t v, input int tag);
    logic [DB-1:0] words [3];
    int   t0, reqc, valc, nxt;
    bit   got_done, advance;
    logic [AB-1:0] a;
    words[0] = v.w0; words[1] = v.w1; words[2] = v.w2;
    reqc = 0; valc = 0; got_done = 0; advance = 0;
    for (int i = 0; i <= int'(v.len) && i < 3; i++) begin
      a = v.addr + AB'(i);
      mem[a] = v.wr ? '0 : words[i];
    end
    @(negedge in_clk);
    in_start = 1'b1; in_wr = v.wr; in_addr = v.addr; in_len = v.len; in_wdata = words[0];
    @(negedge in_clk);
    in_start = 1'b0; in_wdata = words[1];
    t0 = cyc;
    chk($sformatf("f%0d_t0_cs", tag), {31'd0, tw_bus_chipselect}, 32'd0);
    chk($sformatf("f%0d_t0_busy", tag), {31'd0, out_busy}, 32'd1);
    chk($sformatf("f%0d_t0_clk", tag), {31'd0, tw_bus_clock}, 32'd0);
    chk($sformatf("f%0d_t0_data", tag), {31'd0, tw_bus_data}, {31'd0, v.wr});
    for (int c = 0; c < 3000 && !got_done; c++) begin
      @(negedge in_clk);
      if (advance) begin
        nxt = reqc + 1;
        in_wdata = (nxt < 3) ? words[nxt] : '0;
        advance = 0;
      end
      if (out_wdata_req) begin
        chk($sformatf("f%0d_req_time", tag), cyc - t0,
            (2 * (AB + (reqc + 1) * DB) + 2) * DIV - 1);
        reqc++;
        advance = 1;
      end
      if (!v.wr && (cyc - t0) == (2 * (AB + 1)) * DIV + 2)
        chk($sformatf("f%0d_released", tag), {31'd0, tw_bus_data}, 32'd0);
      if (out_rdata_valid) begin
        chk($sformatf("f%0d_rdata%0d", tag, valc), out_rdata, words[valc % 3]);
        valc++;
      end
      if (out_done) begin
        got_done = 1;
        chk($sformatf("f%0d_done_time", tag), cyc - t0, v.exp_cycles);
        chk($sformatf("f%0d_done_cs", tag), {30'd0, tw_bus_chipselect, out_busy}, 32'd2);
      end
    end
    if (!got_done) chk($sformatf("f%0d_timeout", tag), 32'd0, 32'd1);
    @(negedge in_clk);
    chk($sformatf("f%0d_rises", tag), frame_rises, v.exp_rises);
    chk($sformatf("f%0d_mode", tag), {31'd0, s_mode}, {31'd0, v.wr});
    chk($sformatf("f%0d_addr", tag), {22'd0, s_addr}, {22'd0, v.addr});
    chk($sformatf("f%0d_reqs", tag), reqc, v.exp_req);
    chk($sformatf("f%0d_valids", tag), valc, v.exp_valid);
    if (v.wr) begin
      for (int i = 0; i <= int'(v.len) && i < 3; i++) begin
        a = v.addr + AB'(i);
        chk($sformatf("f%0d_mem%0d", tag, i), mem[a], words[i]);
      end
    end
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_cs"},    {31'd0, tw_bus_chipselect}, 32'd1);
    chk({name, "_clk"},   {31'd0, tw_bus_clock}, 32'd0);
    chk({name, "_data"},  {31'd0, tw_bus_data}, 32'd0);
    chk({name, "_flags"}, {28'd0, out_busy, out_done, out_wdata_req, out_rdata_valid}, 32'd0);
    chk({name, "_rdata"}, out_rdata, 32'd0);
  endtask

  vec_t vecs [4];
  int   rises_seen;
  int   strobes;
  bit   hit;
  vec_t probe;

  initial begin
    vecs[0] = '{1'b1, 10'h155, 8'd0, 32'hDEADBEEF, 32'h0, 32'h0, 43, 348, 0, 0};
    vecs[1] = '{1'b1, 10'h040, 8'd2, 32'h11111111, 32'h22222222, 32'h33333333, 107, 860, 2, 0};
    vecs[2] = '{1'b0, 10'h3FF, 8'd1, 32'h12345678, 32'h9ABCDEF0, 32'h0, 75, 604, 0, 2};
    vecs[3] = '{1'b1, 10'h3FF, 8'd1, 32'hCAFEF00D, 32'h0BADF00D, 32'h0, 75, 604, 1, 0};

    // Reset held three cycles while in_start toggles; start on the last reset cycle.
    in_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge in_clk);
      in_start = (i != 1);
    end
    @(negedge in_clk);
    in_start = 1'b0;
    chk_idle("rst");
    in_rst = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge in_clk);
    chk_idle("post_rst");

    for (int i = 0; i < 4; i++) run_frame(vecs[i], i);

    // Start pulse in the middle of a frame must not disturb it.
    probe = '{1'b1, 10'h0AA, 8'd0, 32'h0F0F0F0F, 32'h0, 32'h0, 43, 348, 0, 0};
    fork
      run_frame(probe, 10);
      begin
        for (int i = 0; i < 60; i++) @(negedge in_clk);
        in_start = 1'b1; in_wr = 1'b0; in_addr = 10'h001; in_len = 8'd5;
        @(negedge in_clk);
        in_start = 1'b0;
      end
    join

    // Reset on the 20th bus-clock rising edge aborts the frame silently.
    @(negedge in_clk);
    in_start = 1'b1; in_wr = 1'b1; in_addr = 10'h123; in_len = 8'd3; in_wdata = 32'hA5A5A5A5;
    @(negedge in_clk);
    in_start = 1'b0;
    rises_seen = 0;
    hit = 0;
    for (int c = 0; c < 400 && !hit; c++) begin
      @(negedge in_clk);
      if (tw_bus_clock && !s_prev) rises_seen++;
      if (rises_seen == 20) hit = 1;
    end
    chk("abort_reach20", {31'd0, hit}, 32'd1);
    in_rst = 1'b1;
    @(negedge in_clk);
    in_rst = 1'b0;
    chk("abort_cs",   {31'd0, tw_bus_chipselect}, 32'd1);
    chk("abort_clk",  {31'd0, tw_bus_clock}, 32'd0);
    chk("abort_busy", {31'd0, out_busy}, 32'd0);
    strobes = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_done || out_rdata_valid || out_wdata_req || !tw_bus_chipselect) strobes++;
      @(negedge in_clk);
    end
    chk("abort_quiet", strobes, 0);

    run_frame(vecs[2], 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
